// File: rtl/key_unlock_loader.sv
// ============================================================================
// key_unlock_loader: receives a serial activation key, checks even parity, and
// commits it to a locked core. Repeated bad loads latch a permanent lockout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_unlock_loader #(
  parameter int               KEY_W    = 3,
  parameter logic [KEY_W-1:0] DECOY    = '0,
  parameter int               MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             locked_out,
  output logic             busy
);

  localparam int BW = $clog2(KEY_W + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_load    = 3'd1;
  localparam logic [2:0] c_st_check   = 3'd2;
  localparam logic [2:0] c_st_active  = 3'd3;
  localparam logic [2:0] c_st_error   = 3'd4;
  localparam logic [2:0] c_st_lockout = 3'd5;

  localparam logic [BW-1:0] c_parity_idx = BW'(KEY_W);
  localparam logic [FW-1:0] c_max_fail   = FW'(MAX_FAIL);

  logic [2:0]       r_state;
  logic [KEY_W-1:0] r_shadow;
  logic [BW-1:0]    r_bit_cnt;
  logic [FW-1:0]    r_fail_cnt;
  logic             r_par;
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_valid;
  logic             r_load_err;
  logic             r_locked_out;
  logic             r_busy;

  logic [FW-1:0]    w_fail_inc;

  assign w_fail_inc = r_fail_cnt + FW'(1);

  assign ser_ready  = (r_state == c_st_load);
  assign key_out    = r_key_out;
  assign key_valid  = r_key_valid;
  assign load_err   = r_load_err;
  assign locked_out = r_locked_out;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_shadow     <= '0;
      r_bit_cnt    <= '0;
      r_fail_cnt   <= '0;
      r_par        <= 1'b0;
      r_key_out    <= DECOY;
      r_key_valid  <= 1'b0;
      r_load_err   <= 1'b0;
      r_locked_out <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle, c_st_active, c_st_error: begin
          // Any new load withdraws the committed key before the first bit arrives.
          if (start) begin
            r_state     <= c_st_load;
            r_bit_cnt   <= '0;
            r_par       <= 1'b0;
            r_key_out   <= DECOY;
            r_key_valid <= 1'b0;
            r_load_err  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        c_st_load: begin
          if (ser_valid) begin
            r_par <= r_par ^ ser_data;
            if (r_bit_cnt == c_parity_idx) begin
              r_state <= c_st_check;
            end else begin
              for (int i = 0; i < KEY_W; i++) begin
                if (r_bit_cnt == BW'(i)) r_shadow[i] <= ser_data;
              end
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        c_st_check: begin
          r_busy <= 1'b0;
          if (!r_par) begin
            r_state     <= c_st_active;
            r_key_out   <= r_shadow;
            r_key_valid <= 1'b1;
            r_load_err  <= 1'b0;
            r_fail_cnt  <= '0;
          end else begin
            r_fail_cnt <= w_fail_inc;
            r_load_err <= 1'b1;
            if (w_fail_inc == c_max_fail) begin
              r_state      <= c_st_lockout;
              r_locked_out <= 1'b1;
            end else begin
              r_state <= c_st_error;
            end
          end
        end
        c_st_lockout: begin
          r_key_out    <= DECOY;
          r_key_valid  <= 1'b0;
          r_locked_out <= 1'b1;
        end
        default: begin
          r_state   <= c_st_idle;
          r_key_out <= DECOY;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_unlock_loader.sv
// ============================================================================
// tb_key_unlock_loader: directed self-checking bench for key_unlock_loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_unlock_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ser_valid;
  logic       ser_data;
  logic       ser_ready;
  logic [2:0] key_out;
  logic       key_valid;
  logic       load_err;
  logic       locked_out;
  logic       busy;

  int total;
  int bad;

  key_unlock_loader #(
    .KEY_W    (3),
    .DECOY    (3'b000),
    .MAX_FAIL (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_ready  (ser_ready),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .load_err   (load_err),
    .locked_out (locked_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_data  = b;
    tick();
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  // Full load of three key bits (LSB first) plus parity, then the CHECK cycle.
  task automatic load_key(input logic [2:0] k, input logic p);
    pulse_start();
    send_bit(k[0]);
    send_bit(k[1]);
    send_bit(k[2]);
    send_bit(p);
    tick();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    tick();
    tick();
    check("rst_key_out",   64'(key_out),    64'h0);
    check("rst_key_valid", 64'(key_valid),  64'h0);
    check("rst_load_err",  64'(load_err),   64'h0);
    check("rst_locked",    64'(locked_out), 64'h0);
    check("rst_ser_ready", 64'(ser_ready),  64'h0);
    check("rst_busy",      64'(busy),       64'h0);
    rst_n = 1'b1;
    tick();

    // Good load of 3'b101
    pulse_start();
    check("t1_ready_load", 64'(ser_ready), 64'h1);
    check("t1_busy_load",  64'(busy),      64'h1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t1_ready_bits", 64'(ser_ready), 64'h1);
    send_bit(1'b0);
    check("t1_ready_check", 64'(ser_ready), 64'h0);
    check("t1_busy_check",  64'(busy),      64'h1);
    check("t1_kv_check",    64'(key_valid), 64'h0);
    tick();
    check("t1_key_out",   64'(key_out),   64'h5);
    check("t1_key_valid", 64'(key_valid), 64'h1);
    check("t1_load_err",  64'(load_err),  64'h0);
    check("t1_busy_done", 64'(busy),      64'h0);

    // Reload from ACTIVE; start held during CHECK must be ignored
    pulse_start();
    check("t5_kv_drop",  64'(key_valid), 64'h0);
    check("t5_decoy",    64'(key_out),   64'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_key_out",   64'(key_out),   64'h2);
    check("t5_key_valid", 64'(key_valid), 64'h1);
    check("t5_no_reload", 64'(busy),      64'h0);

    // Stalled link: invalid cycles carry a wrong data bit that must not land
    pulse_start();
    send_bit(1'b1);
    ser_data = 1'b0;
    tick();
    tick();
    check("t2_stall_ready", 64'(ser_ready), 64'h1);
    send_bit(1'b1);
    tick();
    send_bit(1'b0);
    send_bit(1'b0);
    tick();
    check("t2_key_out",   64'(key_out),   64'h3);
    check("t2_key_valid", 64'(key_valid), 64'h1);

    // Bad parity, then recovery
    load_key(3'b001, 1'b0);
    check("t3_load_err",  64'(load_err),   64'h1);
    check("t3_decoy",     64'(key_out),    64'h0);
    check("t3_kv",        64'(key_valid),  64'h0);
    check("t3_not_lock",  64'(locked_out), 64'h0);
    pulse_start();
    check("t3_err_clear", 64'(load_err), 64'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    tick();
    check("t3_key_out",   64'(key_out),  64'h6);
    check("t3_err_after", 64'(load_err), 64'h0);

    // Only consecutive failures count toward lockout
    load_key(3'b001, 1'b0);
    load_key(3'b001, 1'b0);
    check("t4_two_bad", 64'(locked_out), 64'h0);
    load_key(3'b101, 1'b0);
    check("t4_good_mid", 64'(key_out), 64'h5);
    load_key(3'b001, 1'b0);
    load_key(3'b001, 1'b0);
    check("t4_cnt_cleared", 64'(locked_out), 64'h0);
    load_key(3'b001, 1'b0);
    check("t4_locked",   64'(locked_out), 64'h1);
    check("t4_lock_err", 64'(load_err),   64'h1);
    load_key(3'b101, 1'b0);
    check("t4_lock_ready", 64'(ser_ready),  64'h0);
    check("t4_lock_key",   64'(key_out),    64'h0);
    check("t4_lock_kv",    64'(key_valid),  64'h0);
    check("t4_lock_busy",  64'(busy),       64'h0);
    check("t4_lock_hold",  64'(locked_out), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_unlock", 64'(locked_out), 64'h0);
    check("t4_rst_ready",  64'(ser_ready),  64'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // Async reset mid-load, then a good load, then async reset while ACTIVE
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b0);
    check("t6_busy_mid", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  64'(busy),      64'h0);
    check("t6_rst_key",   64'(key_out),   64'h0);
    check("t6_rst_ready", 64'(ser_ready), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();
    load_key(3'b111, 1'b1);
    check("t6_key_out",   64'(key_out),   64'h7);
    check("t6_key_valid", 64'(key_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_act_rst_key", 64'(key_out),   64'h0);
    check("t6_act_rst_kv",  64'(key_valid), 64'h0);
    #1;
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
